// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM
// state encoding and the size-to-byte-count helper.
package lsu_pkg;

  localparam logic [1:0] SZ_NONE  = 2'b00;
  localparam logic [1:0] SZ_BYTE  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Number of bytes touched by an access of the given size (0 for illegal).
  function automatic logic [3:0] size_nbytes(input logic [1:0] size);
    case (size)
      SZ_BYTE:  return 4'd1;
      SZ_WORD:  return 4'd4;
      SZ_DWORD: return 4'd8;
      default:  return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake between the execute stage (master) and the
// load/store unit (slave).
interface lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/lsu_ext.sv
// Combinational load-data extension: picks the accessed bytes out of the
// RAM read word and zero- or sign-extends them to 64 bits.
module lsu_ext
  import lsu_pkg::*;
(
  input  logic [63:0] q,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [63:0] result
);

  // Select and extend according to access size; dword ignores the sign flag.
  // NOTE: result gets a default first so no path through the case leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    result = '0;
    case (size)
      SZ_BYTE:  result = {{56{sgn & q[7]}},  q[7:0]};
      SZ_WORD:  result = {{32{sgn & q[31]}}, q[31:0]};
      SZ_DWORD: result = q;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request at a time, checks size, alignment
// and address range, drives the data RAM for one EXEC cycle and returns the
// extended load result. Errored requests skip the RAM entirely.
module lsu
  import lsu_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lsu_if.slave                 bus,
  output logic                 ram_load,
  output logic [1:0]           ram_wr,
  output logic [15:0]          ram_addr,
  output logic [63:0]          ram_d,
  input  logic [63:0]          ram_q,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  state_t      state, state_nxt;

  logic        we_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [15:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        req_err;
  logic [16:0] last_byte;
  logic        range_err;
  logic        align_err;
  logic [63:0] load_ext;

  // Error check on the incoming request; the last byte address is formed at
  // 17 bits so a carry out of the 16-bit space is visible.
  always_comb begin
    last_byte = {1'b0, bus.req_addr} + {13'd0, size_nbytes(bus.req_size)} - 17'd1;
    range_err = last_byte > 17'h0FFFF;
    align_err = ALIGN_CHECK &&
                (((bus.req_size == SZ_WORD)  && (bus.req_addr[1:0] != 2'b00)) ||
                 ((bus.req_size == SZ_DWORD) && (bus.req_addr[2:0] != 3'b000)));
    req_err   = (bus.req_size == SZ_NONE) || range_err || align_err;
  end

  lsu_ext u_ext (
    .q      (ram_q),
    .size   (size_q),
    .sgn    (sgn_q),
    .result (load_ext)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake/RAM-strobe decode from the current state.
  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    bus.req_ready = 1'b0;
    bus.resp_valid = 1'b0;
    ram_load      = 1'b0;
    ram_wr        = SZ_NONE;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        accept        = bus.req_valid;
        if (bus.req_valid) state_nxt = req_err ? RESP : EXEC;
      end
      EXEC: begin
        ram_load  = we_q;
        ram_wr    = size_q;
        state_nxt = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, response data/error and saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= SZ_NONE;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        size_q  <= bus.req_size;
        sgn_q   <= bus.req_signed;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        err_q   <= req_err;
        rdata_q <= '0;
        if (req_err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
      end
      if (state == EXEC) rdata_q <= we_q ? 64'd0 : load_ext;
    end
  end

  assign ram_addr       = addr_q;
  assign ram_d          = wdata_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the load/store unit with a byte-array RAM model.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ram_load;
  logic [1:0]  ram_wr;
  logic [15:0] ram_addr;
  logic [63:0] ram_d;
  logic [63:0] ram_q;
  logic [7:0]  err_cnt;

  lsu_if bus();

  lsu #(.ALIGN_CHECK(1'b1), .ERR_CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ram_load (ram_load),
    .ram_wr   (ram_wr),
    .ram_addr (ram_addr),
    .ram_d    (ram_d),
    .ram_q    (ram_q),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-addressable RAM: synchronous write, combinational 8-byte read.
  logic [7:0] mem [65536];

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < int'(size_nbytes(ram_wr)); i++)
        mem[16'(ram_addr + 16'(i))] <= ram_d[8*i +: 8];
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) ram_q[8*i +: 8] = mem[16'(ram_addr + 16'(i))];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one request, wait (bounded) for the response, then complete it.
  // lat counts edges from acceptance to resp_valid; loads counts ram_load cycles.
  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [15:0] addr, input logic [63:0] wdata,
                         output logic [63:0] rdata, output logic err,
                         output int lat, output int loads, output logic [1:0] wr_seen);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 1; loads = 0; wr_seen = 2'b00;
    @(negedge clk);
    loads += int'(ram_load);
    wr_seen |= ram_wr;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      loads += int'(ram_load);
      wr_seen |= ram_wr;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
  endtask

  logic [63:0] rd;
  logic        er;
  int          lat, loads;
  logic [1:0]  wrs;
  logic [63:0] hold_rd;
  logic        hold_er;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = SZ_NONE;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_req_ready",  64'(bus.req_ready),  64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_err",   64'(bus.resp_err),   64'd0);
    check("rst_resp_rdata", bus.resp_rdata,      64'd0);
    check("rst_err_cnt",    64'(err_cnt),        64'd0);
    check("rst_ram_load",   64'(ram_load),       64'd0);
    rst_n = 1'b1;

    // Dword store then load back
    run_req(1'b1, SZ_DWORD, 1'b0, 16'h0010, 64'h1122334455667788, rd, er, lat, loads, wrs);
    check("st_d_err",   64'(er),    64'd0);
    check("st_d_loads", 64'(loads), 64'd1);
    check("st_d_wr",    64'(wrs),   64'(SZ_DWORD));
    check("st_d_rdata", rd,         64'd0);
    run_req(1'b0, SZ_DWORD, 1'b0, 16'h0010, 64'd0, rd, er, lat, loads, wrs);
    check("ld_d_rdata", rd,         64'h1122334455667788);
    check("ld_d_lat",   64'(lat),   64'd2);
    check("ld_d_loads", 64'(loads), 64'd0);

    // Byte store then signed/unsigned loads
    run_req(1'b1, SZ_BYTE, 1'b0, 16'h0020, 64'hDEADBEEFCAFE0088, rd, er, lat, loads, wrs);
    check("st_b_wr", 64'(wrs), 64'(SZ_BYTE));
    run_req(1'b0, SZ_BYTE, 1'b1, 16'h0020, 64'd0, rd, er, lat, loads, wrs);
    check("ld_b_signed", rd, 64'hFFFFFFFFFFFFFF88);
    run_req(1'b0, SZ_BYTE, 1'b0, 16'h0020, 64'd0, rd, er, lat, loads, wrs);
    check("ld_b_unsigned", rd, 64'h0000000000000088);

    // Word store/load with sign extension
    run_req(1'b1, SZ_WORD, 1'b0, 16'h0040, 64'h0000000080001234, rd, er, lat, loads, wrs);
    run_req(1'b0, SZ_WORD, 1'b1, 16'h0040, 64'd0, rd, er, lat, loads, wrs);
    check("ld_w_signed", rd, 64'hFFFFFFFF80001234);
    run_req(1'b0, SZ_WORD, 1'b0, 16'h0040, 64'd0, rd, er, lat, loads, wrs);
    check("ld_w_unsigned", rd, 64'h0000000080001234);

    // Misaligned word load
    run_req(1'b0, SZ_WORD, 1'b0, 16'h0003, 64'd0, rd, er, lat, loads, wrs);
    check("mis_err",   64'(er),      64'd1);
    check("mis_lat",   64'(lat),     64'd1);
    check("mis_loads", 64'(loads),   64'd0);
    check("mis_wr",    64'(wrs),     64'd0);
    check("mis_rdata", rd,           64'd0);
    check("mis_cnt",   64'(err_cnt), 64'd1);

    // Address range and illegal size
    run_req(1'b0, SZ_DWORD, 1'b0, 16'hFFF9, 64'd0, rd, er, lat, loads, wrs);
    check("rng_fff9_err", 64'(er), 64'd1);
    run_req(1'b0, SZ_DWORD, 1'b0, 16'hFFF8, 64'd0, rd, er, lat, loads, wrs);
    check("rng_fff8_err", 64'(er), 64'd0);
    check("rng_fff8_lat", 64'(lat), 64'd2);
    run_req(1'b0, SZ_NONE, 1'b0, 16'h0100, 64'd0, rd, er, lat, loads, wrs);
    check("sz0_err", 64'(er),      64'd1);
    check("sz0_cnt", 64'(err_cnt), 64'd3);

    // Backpressure: response held while a competing store is offered
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_size   = SZ_DWORD;
    bus.req_signed = 1'b0;
    bus.req_addr   = 16'h0010;
    @(posedge clk);
    #1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 16'h0050;
    bus.req_wdata = 64'hA5A5A5A5A5A5A5A5;
    @(negedge clk);
    @(negedge clk);
    check("bp_valid_rise", 64'(bus.resp_valid), 64'd1);
    hold_rd = bus.resp_rdata;
    hold_er = bus.resp_err;
    check("bp_rdata", hold_rd, 64'h1122334455667788);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(bus.resp_valid), 64'd1);
      check("bp_hold_rdata", bus.resp_rdata,      hold_rd);
      check("bp_hold_err",   64'(bus.resp_err),   64'(hold_er));
      check("bp_req_ready",  64'(bus.req_ready),  64'd0);
      check("bp_ram_load",   64'(ram_load),       64'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    check("bp_done_valid", 64'(bus.resp_valid), 64'd0);
    check("bp_done_ready", 64'(bus.req_ready),  64'd1);
    check("bp_no_store",   64'(mem[16'h0050]),  64'h00);

    // Reset in the middle of EXEC of a byte store
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_size   = SZ_BYTE;
    bus.req_signed = 1'b0;
    bus.req_addr   = 16'h0030;
    bus.req_wdata  = 64'h000000000000005A;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    check("exec_ram_load", 64'(ram_load), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_exec_load",  64'(ram_load),       64'd0);
    check("rst_exec_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_exec_cnt",   64'(err_cnt),        64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_req(1'b0, SZ_BYTE, 1'b0, 16'h0030, 64'd0, rd, er, lat, loads, wrs);
    check("rst_no_write", rd, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
